// File: rtl/gate_response_checker.sv
// gate_response_checker: exhaustive Gray-order self-test for a 2-input gate.
// Ports: clk, rst_n (async low), start, y (gate output) | a, b (stimulus),
//        busy, done (1-cycle pulse), pass, err_cnt[2:0], fail_mask[3:0].
// Optional: define GATE_CHK_STOP_ON_FAIL_EN to abort the run on first mismatch.
`timescale 1ns/1ps
module gate_response_checker #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter logic [3:0]  EXPECTED    = 4'b0010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [7:0] cnt;
    logic       sample;
    logic       mismatch;
    logic [2:0] err_nxt;

    assign mismatch = (y != EXPECTED[{a, b}]);
    assign err_nxt  = err_cnt + 3'(mismatch);
    assign ptr_nxt  = ptr + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt == HOLD_LAST) begin
                    sample = 1'b1;
                    if (ptr == 2'd3) begin
                        state_nxt = DONE;
                    end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state_nxt = DONE;
                    end
`endif
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector pointer maps to Gray order: a = ptr[1], b = ptr[1] ^ ptr[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 2'd0;
            cnt       <= 8'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= 3'd0;
            fail_mask <= 4'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    a <= 1'b0;
                    b <= 1'b0;
                    if (start) begin
                        busy      <= 1'b1;
                        ptr       <= 2'd0;
                        cnt       <= 8'd0;
                        err_cnt   <= 3'd0;
                        fail_mask <= 4'd0;
                        pass      <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample) begin
                        cnt <= 8'd0;
                        ptr <= ptr_nxt;
                        if (mismatch) begin
                            fail_mask[{a, b}] <= 1'b1;
                            err_cnt           <= err_nxt;
                        end
                        if (state_nxt == DONE) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                            pass <= (err_nxt == 3'd0);
                            a    <= 1'b0;
                            b    <= 1'b0;
                        end else begin
                            a <= ptr_nxt[1];
                            b <= ptr_nxt[1] ^ ptr_nxt[0];
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    a <= 1'b0;
                    b <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker: randomized gate faults vs a truth-table model.
// Covers HOLD_CYCLES=10 and HOLD_CYCLES=2 instances, restart/reset cases.
`timescale 1ns/1ps
module tb_gate_response_checker;

    logic       clk;
    logic       rst_n;
    logic       start1, start2;
    logic [3:0] fn1, fn2;
    logic       y1, y2;
    logic       a1, b1, busy1, done1, pass1;
    logic       a2, b2, busy2, done2, pass2;
    logic [2:0] ec1, ec2;
    logic [3:0] fm1, fm2;

    logic       sel;
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [2:0] ec_s;
    logic [3:0] fm_s;

    int n_chk;
    int n_fail;

    localparam logic [3:0] GOOD = 4'b0010;

    assign y1 = fn1[{a1, b1}];
    assign y2 = fn2[{a2, b2}];

    gate_response_checker #(.HOLD_CYCLES(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(ec1), .fail_mask(fm1)
    );

    gate_response_checker #(.HOLD_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(ec2), .fail_mask(fm2)
    );

    always_comb begin
        a_s    = sel ? a2 : a1;
        b_s    = sel ? b2 : b1;
        busy_s = sel ? busy2 : busy1;
        done_s = sel ? done2 : done1;
        pass_s = sel ? pass2 : pass1;
        ec_s   = sel ? ec2 : ec1;
        fm_s   = sel ? fm2 : fm1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] gray(input int i);
        logic [1:0] g [4];
        g = '{2'b00, 2'b01, 2'b11, 2'b10};
        return g[i];
    endfunction

    // Walk the Gray sequence and compare the gate's table to the golden one.
    function automatic void model(input logic [3:0] fn, input int h,
                                  output int lat, output logic [2:0] ec,
                                  output logic [3:0] fm);
        int n;
        n  = 4;
        ec = 3'd0;
        fm = 4'd0;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] v;
            v = gray(k);
            if (fn[v] != GOOD[v]) begin
                fm[v] = 1'b1;
                ec    = ec + 3'd1;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                n = k + 1;
                break;
`endif
            end
        end
        lat = n * h;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy_s || done_s) && guard < 200) begin
            tick();
            guard++;
        end
        chk("idle_wait", 8'(busy_s || done_s), 8'd0);
    endtask

    task automatic run(input logic s, input logic [3:0] fn,
                       input logic poke);
        int         h;
        int         lat;
        logic [2:0] ec;
        logic [3:0] fm;
        sel = s;
        h   = s ? 2 : 10;
        if (s) fn2 = fn;
        else   fn1 = fn;
        model(fn, h, lat, ec, fm);
        wait_idle();
        set_start(1'b1);
        tick();
        set_start(1'b0);
        for (int t = 0; t < lat; t++) begin
            chk("ab_seq", 8'({a_s, b_s}), 8'(gray(t / h)));
            chk("busy_run", 8'(busy_s), 8'd1);
            chk("done_early", 8'(done_s), 8'd0);
            set_start(poke && t == 15);
            tick();
        end
        set_start(1'b0);
        chk("done_pulse", 8'(done_s), 8'd1);
        chk("busy_done", 8'(busy_s), 8'd0);
        chk("pass", 8'(pass_s), 8'(ec == 3'd0));
        chk("err_cnt", 8'(ec_s), 8'(ec));
        chk("fail_mask", 8'(fm_s), 8'(fm));
        chk("ab_done", 8'({a_s, b_s}), 8'd0);
        tick();
        chk("done_clear", 8'(done_s), 8'd0);
        tick();
        chk("no_rerun", 8'(busy_s), 8'd0);
        chk("err_hold", 8'(ec_s), 8'(ec));
        chk("mask_hold", 8'(fm_s), 8'(fm));
        chk("pass_hold", 8'(pass_s), 8'(ec == 3'd0));
    endtask

    initial begin
        int   seen;
        int   guard;
        n_chk  = 0;
        n_fail = 0;
        sel    = 1'b0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        fn1    = GOOD;
        fn2    = GOOD;
        start1 = 1'b1;
        tick();
        tick();
        chk("rst_ab", 8'({a1, b1}), 8'd0);
        chk("rst_busy", 8'(busy1), 8'd0);
        chk("rst_done", 8'(done1), 8'd0);
        chk("rst_pass", 8'(pass1), 8'd0);
        chk("rst_err", 8'(ec1), 8'd0);
        chk("rst_mask", 8'(fm1), 8'd0);
        start1 = 1'b0;
        rst_n  = 1'b1;
        tick();

        run(1'b0, GOOD, 1'b0);
        run(1'b0, 4'b0000, 1'b0);
        run(1'b0, 4'b1111, 1'b0);
        run(1'b0, GOOD, 1'b1);
        run(1'b1, GOOD, 1'b0);
        run(1'b1, 4'b1101, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run(1'($urandom_range(0, 1)), 4'($urandom),
                1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a run.
        sel    = 1'b0;
        fn1    = 4'b1111;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (25) tick();
        chk("mid_busy", 8'(busy1), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_ab", 8'({a1, b1}), 8'd0);
        chk("arst_busy", 8'(busy1), 8'd0);
        chk("arst_err", 8'(ec1), 8'd0);
        chk("arst_mask", 8'(fm1), 8'd0);
        chk("arst_pass", 8'(pass1), 8'd0);
        #2;
        rst_n = 1'b1;
        seen  = 0;
        repeat (50) begin
            tick();
            if (done1 || busy1) seen++;
        end
        chk("no_done_after_rst", 8'(seen), 8'd0);
        run(1'b0, GOOD, 1'b0);

        // Start held high: rerun on the first IDLE cycle after DONE.
        sel    = 1'b0;
        fn1    = GOOD;
        start1 = 1'b1;
        tick();
        guard = 0;
        while (!done1 && guard < 100) begin
            tick();
            guard++;
        end
        chk("held_done", 8'(done1), 8'd1);
        tick();
        chk("held_idle", 8'(busy1), 8'd0);
        tick();
        chk("held_restart", 8'(busy1), 8'd1);
        start1 = 1'b0;
        guard  = 0;
        while (!done1 && guard < 100) begin
            tick();
            guard++;
        end
        chk("held_done2", 8'(done1), 8'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_response_checker.md
Name: gate_response_checker

Overview:
- Sequential stimulus generator and response checker for a 2-input combinational gate under test.
- Drives a/b through all four input combinations in Gray order and holds each vector for a programmable number of cycles.
- Samples the gate output y on each vector, compares it against a parameterised truth table, and reports a per-vector fail mask and an error count.
- Sits beside any lab gate block (e.g. Y = NOT A AND B) as an on-chip exhaustive self-test.

Parameters:
- HOLD_CYCLES, 10, cycles each vector is held before y is sampled; legal range 2..255.
- EXPECTED, 4'b0010, expected y indexed by {a,b}; bit0=00, bit1=01, bit2=10, bit3=11. Default encodes NOT A AND B.

Ports:
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a test run; sampled in IDLE only
- y  input  1  output of the gate under test
- a  output  1  stimulus A to the gate
- b  output  1  stimulus B to the gate
- busy  output  1  high while a run is in progress
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  high when the last run had zero mismatches; valid from done until the next start
- err_cnt  output  3  mismatch count of the last run, 0..4
- fail_mask  output  4  bit i set if vector index i ({a,b}) mismatched in the last run

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=0.
  - The hold counter and vector pointer clear to 0.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - a and b are driven 0.
  - On a clk edge with start=1: enter DRIVE, busy=1, vector pointer=0, hold counter=0, err_cnt=0, fail_mask=0, pass=0.
- Vector sequence by pointer 0..3, matching Gray order: {a,b} = 00, 01, 11, 10.
- a and b are registered and change on the same edge the pointer changes.
- DRIVE:
  - The hold counter increments every cycle.
  - On the edge where counter==HOLD_CYCLES-1, y is sampled and compared against EXPECTED[{a,b}].
  - On mismatch: set fail_mask[{a,b}] and increment err_cnt.
  - On that same edge the counter resets to 0 and the pointer advances.
  - After sampling pointer 3, go to DONE.
- Latency: the start edge to the DONE entry edge is exactly 4*HOLD_CYCLES cycles. busy is high for those 4*HOLD_CYCLES cycles.
- DONE (one cycle): done=1, busy=0, pass=(err_cnt==0), a=b=0, then return to IDLE.
- pass, err_cnt and fail_mask hold their values in IDLE until the next accepted start.
- start while busy=1 or in DONE: ignored, no restart.
- start held high continuously: a new run is accepted on the first IDLE cycle after DONE.
- Reset mid-run: immediate return to reset values. No done pulse; partial results are discarded.
- err_cnt cannot wrap: a maximum of 4 samples per run fits in 3 bits.

Optional Feature:
- Macro: GATE_CHK_STOP_ON_FAIL_EN.
- Defined:
  - On the first mismatch the run aborts on the sampling edge and goes straight to DONE.
  - Only the first failing bit is set in fail_mask; err_cnt=1, pass=0.
  - Latency is (k+1)*HOLD_CYCLES, where k is the failing pointer.
- Not defined: all four vectors always run, as described above.

Test Plan:
- Correct gate (y = ~a & b), default parameters, start pulse:
  - {a,b} sequence 00, 01, 11, 10, each held 10 cycles.
  - done at start+40; pass=1, err_cnt=0, fail_mask=0000.
- Stuck-at-0 y:
  - Vector 01 fails; done at +40.
  - pass=0, err_cnt=1, fail_mask=0010.
- Stuck-at-1 y:
  - err_cnt=3, fail_mask=1101, pass=0.
  - With GATE_CHK_STOP_ON_FAIL_EN: done at +10, fail_mask=0001, err_cnt=1.
- start pulsed again at cycle 15 of a run:
  - Ignored; done still at +40 with no second run.
  - A new start after done clears the results and reruns.
- rst_n asserted at cycle 25 of a run:
  - All outputs go to 0 immediately; no done pulse.
  - After release, start gives a full 40-cycle run.
- HOLD_CYCLES=2, correct gate: done at +8, pass=1; a/b change every 2 cycles.
